shift_sequencer: RTL

//  Multi-cycle controller that sequences the 4-bit-amount barrel shifter to perform full-range shifts/rotates (0..WIDTH-1).

---
 rtl/shift_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: splits a 0..WIDTH-1 amount into passes of at most 15
// through an external 4-bit-amount barrel shifter, registering each intermediate result.
module shift_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [AW-1:0]    i_amt,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_abort,
  output logic [WIDTH-1:0] o_bar_data,
  output logic [3:0]       o_bar_fs,
  output logic [3:0]       o_bar_amt,
  input  logic [WIDTH-1:0] i_bar_result,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_busy
);

  localparam int unsigned  STEP_W   = 4;
  localparam logic [AW-1:0] MAX_STEP = AW'(15);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_work;
  logic [AW-1:0]      r_rem;
  logic [1:0]         r_op;
  logic               r_ready;
  logic               r_valid;
  logic               r_busy;
  logic [STEP_W-1:0]  r_bar_fs;
  logic [STEP_W-1:0]  r_bar_amt;
  logic [AW-1:0]      w_rem_next;

  function automatic logic [STEP_W-1:0] step_of(input logic [AW-1:0] amt);
    return (amt > MAX_STEP) ? STEP_W'(MAX_STEP) : amt[STEP_W-1:0];
  endfunction

  function automatic logic [STEP_W-1:0] fs_of(input logic [1:0] op);
    logic [STEP_W-1:0] fs;
    case (op)
      2'b00:   fs = 4'b1100;
      2'b01:   fs = 4'b1110;
      2'b10:   fs = 4'b1101;
      default: fs = 4'b1111;
    endcase
    return fs;
  endfunction

  // r_bar_amt always holds the step applied in the current RUN cycle
  assign w_rem_next = r_rem - AW'(r_bar_amt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_work    <= '0;
      r_rem     <= '0;
      r_op      <= '0;
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_bar_fs  <= '0;
      r_bar_amt <= '0;
    end else if (i_abort) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_bar_fs  <= '0;
      r_bar_amt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_work  <= i_data;
            r_op    <= i_op;
            r_rem   <= i_amt;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (i_amt != '0) begin
              r_state   <= S_RUN;
              r_bar_fs  <= fs_of(i_op);
              r_bar_amt <= step_of(i_amt);
            end else begin
              r_state <= S_DONE;
              r_valid <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_work <= i_bar_result;
          r_rem  <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state   <= S_DONE;
            r_valid   <= 1'b1;
            r_bar_fs  <= '0;
            r_bar_amt <= '0;
          end else begin
            r_bar_fs  <= fs_of(r_op);
            r_bar_amt <= step_of(w_rem_next);
          end
        end
        S_DONE: begin
          // one idle cycle after handshake before the next accept
          if (i_ready) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_ready   <= 1'b1;
          r_valid   <= 1'b0;
          r_busy    <= 1'b0;
          r_bar_fs  <= '0;
          r_bar_amt <= '0;
        end
      endcase
    end
  end

  assign o_ready    = r_ready;
  assign o_valid    = r_valid;
  assign o_busy     = r_busy;
  assign o_data     = r_work;
  assign o_bar_data = r_work;
  assign o_bar_fs   = r_bar_fs;
  assign o_bar_amt  = r_bar_amt;

endmodule
